// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and formats load data for the
// register file, stalling MEM while a load's read data is outstanding.
module wb_stage #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_MEM,
  input  logic                   RegWrite_MEM,
  input  logic                   MemtoReg_MEM,
  input  logic [4:0]             RD_MEM,
  input  logic [31:0]            ALU_DATA_MEM,
  input  logic [2:0]             FUNCT3_MEM,
  input  logic [1:0]             ADDR_LOW_MEM,
  input  logic [31:0]            MEM_RDATA,
  input  logic                   MEM_RVALID,
  output logic                   stall_MEM,
  output logic                   RegWrite_WB,
  output logic [31:0]            ALU_DATA_WB,
  output logic [4:0]             RD_WB,
  output logic [COUNT_WIDTH-1:0] RETIRED_WB
);

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } state_t;

  state_t state_q, state_d;

  logic                   rw_q;
  logic [31:0]            data_q;
  logic [4:0]             rd_q;
  logic [COUNT_WIDTH-1:0] cnt_q;

  logic [4:0]  rd_l;
  logic        rw_l;
  logic [2:0]  f3_l;
  logic [1:0]  al_l;

  logic        done;
  logic        done_we;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        latch;

  function automatic logic [31:0] fmt(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  al
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*al +: 8];
    h = al[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b100:  fmt = {24'h0, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b101:  fmt = {16'h0, h};
      default: fmt = w;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    done_we   = 1'b0;
    done_rd   = rd_q;
    done_data = data_q;
    latch     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_MEM) begin
          if (!MemtoReg_MEM) begin
            done      = 1'b1;
            done_we   = RegWrite_MEM && (RD_MEM != 5'd0);
            done_rd   = RD_MEM;
            done_data = ALU_DATA_MEM;
          end else if (MEM_RVALID) begin
            done      = 1'b1;
            done_we   = RegWrite_MEM && (RD_MEM != 5'd0);
            done_rd   = RD_MEM;
            done_data = fmt(MEM_RDATA, FUNCT3_MEM, ADDR_LOW_MEM);
          end else begin
            latch   = 1'b1;
            state_d = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        if (MEM_RVALID) begin
          done      = 1'b1;
          done_we   = rw_l && (rd_l != 5'd0);
          done_rd   = rd_l;
          done_data = fmt(MEM_RDATA, f3_l, al_l);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      data_q  <= 32'h0;
      rd_q    <= 5'd0;
      cnt_q   <= '0;
      rd_l    <= 5'd0;
      rw_l    <= 1'b0;
      f3_l    <= 3'd0;
      al_l    <= 2'd0;
    end else begin
      state_q <= state_d;
      rw_q    <= done && done_we;
      if (done) begin
        data_q <= done_data;
        rd_q   <= done_rd;
        cnt_q  <= cnt_q + COUNT_WIDTH'(1);
      end
      if (latch) begin
        rd_l <= RD_MEM;
        rw_l <= RegWrite_MEM;
        f3_l <= FUNCT3_MEM;
        al_l <= ADDR_LOW_MEM;
      end
    end
  end

  assign stall_MEM   = (state_q == WAIT_LOAD);
  assign RegWrite_WB = rw_q;
  assign ALU_DATA_WB = data_q;
  assign RD_WB       = rd_q;
  assign RETIRED_WB  = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writebacks are queued as stimulus
// is driven and checked against the DUT one cycle later.
module tb_wb_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_MEM;
  logic          RegWrite_MEM;
  logic          MemtoReg_MEM;
  logic [4:0]    RD_MEM;
  logic [31:0]   ALU_DATA_MEM;
  logic [2:0]    FUNCT3_MEM;
  logic [1:0]    ADDR_LOW_MEM;
  logic [31:0]   MEM_RDATA;
  logic          MEM_RVALID;
  logic          stall_MEM;
  logic          RegWrite_WB;
  logic [31:0]   ALU_DATA_WB;
  logic [4:0]    RD_WB;
  logic [CW-1:0] RETIRED_WB;

  wb_stage #(.COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_MEM    (valid_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .MemtoReg_MEM (MemtoReg_MEM),
    .RD_MEM       (RD_MEM),
    .ALU_DATA_MEM (ALU_DATA_MEM),
    .FUNCT3_MEM   (FUNCT3_MEM),
    .ADDR_LOW_MEM (ADDR_LOW_MEM),
    .MEM_RDATA    (MEM_RDATA),
    .MEM_RVALID   (MEM_RVALID),
    .stall_MEM    (stall_MEM),
    .RegWrite_WB  (RegWrite_WB),
    .ALU_DATA_WB  (ALU_DATA_WB),
    .RD_WB        (RD_WB),
    .RETIRED_WB   (RETIRED_WB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [4:0]  last_rd   = 5'd0;
  logic [31:0] last_data = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [2:0] f3, input logic [1:0] al,
                       input logic [31:0] rdata, input logic rv);
    valid_MEM    = v;
    RegWrite_MEM = rw;
    MemtoReg_MEM = m2r;
    RD_MEM       = rd;
    ALU_DATA_MEM = alu;
    FUNCT3_MEM   = f3;
    ADDR_LOW_MEM = al;
    MEM_RDATA    = rdata;
    MEM_RVALID   = rv;
  endtask

  task automatic expect_wb(input logic we, input logic [4:0] rd,
                           input logic [31:0] data);
    wb_t e;
    e.we = we;
    e.rd = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag, input logic exp_stall);
    wb_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_cnt++;
      last_rd = e.rd;
      last_data = e.data;
      chk({tag, ".we"}, 32'(RegWrite_WB), 32'(e.we));
    end else begin
      chk({tag, ".idle_we"}, 32'(RegWrite_WB), 32'd0);
    end
    chk({tag, ".rd"}, 32'(RD_WB), 32'(last_rd));
    chk({tag, ".data"}, ALU_DATA_WB, last_data);
    chk({tag, ".cnt"}, 32'(RETIRED_WB), 32'(exp_cnt));
    chk({tag, ".stall"}, 32'(stall_MEM), 32'(exp_stall));
  endtask

  task automatic rst_tick(input string tag);
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    exp_cnt = '0;
    last_rd = 5'd0;
    last_data = 32'h0;
    chk({tag, ".we"}, 32'(RegWrite_WB), 32'd0);
    chk({tag, ".rd"}, 32'(RD_WB), 32'd0);
    chk({tag, ".data"}, ALU_DATA_WB, 32'd0);
    chk({tag, ".cnt"}, 32'(RETIRED_WB), 32'd0);
    chk({tag, ".stall"}, 32'(stall_MEM), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_tick("rst0");
    reset = 1'b0;
    rst_tick("rst1");

    drive(1, 1, 0, 5'd5, 32'h12345678, 0, 0, 0, 0);
    expect_wb(1, 5'd5, 32'h12345678);
    tick("alu", 0);

    drive(1, 1, 0, 5'd0, 32'hDEADBEEF, 0, 0, 0, 0);
    expect_wb(0, 5'd0, 32'hDEADBEEF);
    tick("x0", 0);

    drive(1, 0, 0, 5'd7, 32'h0000AAAA, 0, 0, 0, 0);
    expect_wb(0, 5'd7, 32'h0000AAAA);
    tick("norw", 0);

    drive(0, 1, 1, 5'd9, 32'h1, 3'b010, 0, 32'h55555555, 1);
    tick("idle_rv", 0);

    drive(1, 1, 1, 5'd3, 0, 3'b000, 2'd3, 32'h80FF0000, 1);
    expect_wb(1, 5'd3, 32'hFFFFFF80);
    tick("lb", 0);

    drive(1, 1, 1, 5'd4, 0, 3'b100, 2'd3, 32'h80FF0000, 1);
    expect_wb(1, 5'd4, 32'h00000080);
    tick("lbu", 0);

    drive(1, 1, 1, 5'd6, 0, 3'b101, 2'd2, 32'h80FF0000, 1);
    expect_wb(1, 5'd6, 32'h000080FF);
    tick("lhu", 0);

    drive(1, 1, 1, 5'd8, 0, 3'b010, 2'd1, 32'h80FF0000, 1);
    expect_wb(1, 5'd8, 32'h80FF0000);
    tick("lw", 0);

    drive(1, 1, 1, 5'd10, 0, 3'b001, 2'd0, 32'h80017FFF, 1);
    expect_wb(1, 5'd10, 32'h00007FFF);
    tick("lh0", 0);

    // delayed LH; MEM presents unrelated fields while stalled
    drive(1, 1, 1, 5'd9, 0, 3'b001, 2'd2, 32'h0, 0);
    tick("dlh_acc", 1);
    drive(1, 1, 0, 5'd12, 32'hCAFEF00D, 3'b010, 2'd0, 32'h0, 0);
    tick("dlh_w1", 1);
    tick("dlh_w2", 1);
    tick("dlh_w3", 1);
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'h80017FFF;
    expect_wb(1, 5'd9, 32'hFFFF8001);
    tick("dlh_done", 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("dlh_after", 0);

    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 5'(20 + i), 32'hA0 + 32'(i), 0, 0, 0, 0);
      expect_wb(1, 5'(20 + i), 32'hA0 + 32'(i));
      tick("b2b", 0);
    end

    drive(1, 1, 1, 5'd11, 0, 3'b010, 0, 0, 0);
    tick("rw_acc", 1);
    drive(1, 1, 0, 5'd13, 32'h77, 3'b010, 0, 32'h1234, 1);
    rst_tick("rw_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 32'h1234, 1);
    tick("rw_stale", 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("rw_quiet", 0);

    rst_tick("rst2");
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 5'd1, 32'(i), 0, 0, 0, 0);
      expect_wb(1, 5'd1, 32'(i));
      tick("wrap", 0);
    end
    chk("wrap_zero", 32'(RETIRED_WB), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The module SHALL have parameter COUNT_WIDTH, default 32, giving the width of the retired-writeback counter.
REQ-002 The module SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The module SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-004 The module SHALL have port valid_MEM  input  1  an instruction is presented from MEM.
REQ-005 The module SHALL have port RegWrite_MEM  input  1  the instruction writes rd.
REQ-006 The module SHALL have port MemtoReg_MEM  input  1  the instruction is a load; its result comes from memory.
REQ-007 The module SHALL have port RD_MEM  input  5  destination register.
REQ-008 The module SHALL have port ALU_DATA_MEM  input  32  ALU result for non-loads.
REQ-009 The module SHALL have port FUNCT3_MEM  input  3  load type.
REQ-010 The module SHALL have port ADDR_LOW_MEM  input  2  load byte offset, address[1:0].
REQ-011 The module SHALL have port MEM_RDATA  input  32  memory read word, little-endian.
REQ-012 The module SHALL have port MEM_RVALID  input  1  MEM_RDATA is valid this cycle.
REQ-013 The module SHALL have port stall_MEM  output  1  backpressure: MEM holds its instruction.
REQ-014 The module SHALL have port RegWrite_WB  output  1  register-file write enable toward ID.
REQ-015 The module SHALL have port ALU_DATA_WB  output  32  register-file write data toward ID.
REQ-016 The module SHALL have port RD_WB  output  5  register-file write address toward ID.
REQ-017 The module SHALL have port RETIRED_WB  output  COUNT_WIDTH  count of completed writeback slots.

Function
REQ-018 An instruction SHALL be accepted on a rising edge where valid_MEM=1 and stall_MEM=0.
REQ-019 The FSM SHALL have two states: IDLE and WAIT_LOAD; stall_MEM SHALL be 1 exactly when the state is WAIT_LOAD (decoded from the registered state).
REQ-020 For an accepted non-load (MemtoReg_MEM=0), the cycle after acceptance SHALL present RD_WB=RD_MEM, ALU_DATA_WB=ALU_DATA_MEM, and RegWrite_WB=RegWrite_MEM AND (RD_MEM!=0).
REQ-021 For an accepted load with MEM_RVALID=1 in the same cycle, the following cycle SHALL present the formatted load data, using the same RD_WB and RegWrite_WB rules as REQ-020.
REQ-022 For an accepted load with MEM_RVALID=0, the module SHALL latch RD, RegWrite, FUNCT3 and ADDR_LOW, then move to WAIT_LOAD.
REQ-023 In WAIT_LOAD, an edge with MEM_RVALID=1 SHALL move the FSM to IDLE and present the formatted data from the latched fields in the next cycle; MEM_RVALID=0 SHALL hold WAIT_LOAD with RegWrite_WB=0.
REQ-024 In IDLE, MEM_RVALID SHALL be ignored unless a load is accepted on the same edge; valid_MEM SHALL be ignored while stall_MEM=1.
REQ-025 Load formatting SHALL be: byte k = MEM_RDATA[8k+7:8k]; LB (000) sign-extends byte ADDR_LOW; LBU (100) zero-extends byte ADDR_LOW; LH (001) sign-extends the halfword selected by ADDR_LOW[1]; LHU (101) zero-extends that halfword; LW (010) and all other codes pass the full word.
REQ-026 RegWrite_WB SHALL be 1 for one cycle only per completed slot; in cycles without a completion it SHALL be 0 while ALU_DATA_WB and RD_WB hold their last values.
REQ-027 Each completed slot (a non-load acceptance or a load-data capture) SHALL increment RETIRED_WB by 1 in the same cycle the writeback is presented, including slots with rd=0 or RegWrite=0, and the counter SHALL wrap modulo 2^COUNT_WIDTH.
REQ-028 Back-to-back non-loads SHALL complete one per cycle with no bubbles.

Reset
REQ-029 On an edge with reset=0, the module SHALL set the state to IDLE and force stall_MEM=0, RegWrite_WB=0, ALU_DATA_WB=0, RD_WB=0 and RETIRED_WB=0.
REQ-030 Reset SHALL discard any pending load, and MEM_RVALID pulses during or after reset that belong to that load SHALL cause no writeback.
REQ-031 reset SHALL take priority over every simultaneous input event.

Verification
REQ-032 ALU write: accept RegWrite=1, MemtoReg=0, RD=5, ALU_DATA=0x12345678 -> next cycle RegWrite_WB=1, RD_WB=5, ALU_DATA_WB=0x12345678, RETIRED_WB=1.
REQ-033 x0 suppression: accept RegWrite=1, RD=0 -> RegWrite_WB=0 and RETIRED_WB increments.
REQ-034 Same-cycle loads, MEM_RDATA=0x80FF0000, ADDR_LOW=3: LB -> 0xFFFFFF80; LBU -> 0x00000080; ADDR_LOW=2 with LHU -> 0x000080FF.
REQ-035 Delayed LH: accept with ADDR_LOW=2, MEM_RVALID=0 for 3 cycles, then 1 with MEM_RDATA=0x80017FFF -> stall_MEM=1 for 4 cycles, ending in the rvalid cycle; next cycle ALU_DATA_WB=0xFFFF8001 with a single RegWrite_WB pulse.
REQ-036 Reset while in WAIT_LOAD, then a MEM_RVALID pulse -> all outputs 0, state IDLE, no writeback.
REQ-037 COUNT_WIDTH=4: 16 consecutive non-load completions -> RETIRED_WB wraps to 0.
